// File: rtl/mul_pkg.sv
// Shared definitions for the radix-4 Booth multiplier family:
// digit encodings, FSM states and the iteration-count helper.
package mul_pkg;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // One digit per bit pair of the (W+2)-bit extended multiplier.
  function automatic int booth_iter(input int w);
    return w / 2 + 1;
  endfunction

  // Window is {m[2i+1], m[2i], m[2i-1]}.
  function automatic booth_digit_t booth_recode(input logic [2:0] window);
    booth_digit_t d;
    case (window)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth partial-product selector: recodes a 3-bit window and returns
// the selected multiple of the multiplicand; negation is invert plus carry-in.
module booth_r4_sel
  import mul_pkg::*;
#(
  parameter int MW = 36
) (
  input  logic [2:0]    window,
  input  logic [MW-1:0] mcand,
  output logic [MW-1:0] pp,
  output logic          neg
);

  booth_digit_t digit;
  logic [MW-1:0] mcand_x2;

  assign digit    = booth_recode(window);
  assign mcand_x2 = {mcand[MW-2:0], 1'b0};

  always_comb begin
    pp  = '0;
    neg = 1'b0;
    case (digit)
      POS1: pp = mcand;
      POS2: pp = mcand_x2;
      NEG1: begin
        pp  = ~mcand;
        neg = 1'b1;
      end
      NEG2: begin
        pp  = ~mcand_x2;
        neg = 1'b1;
      end
      default: begin
        pp  = '0;
        neg = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mul_booth_iter.sv
// Iterative radix-4 Booth multiplier: one digit per cycle through one adder,
// per-operand signedness, valid/ready on both sides, synchronous flush.
module mul_booth_iter
  import mul_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   op1,
  input  logic [W-1:0]   op2,
  input  logic           op1_signed,
  input  logic           op2_signed,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] res
);

  localparam int ITER = booth_iter(W);
  localparam int AW   = 2 * W + 4;
  localparam int CW   = $clog2(ITER + 1);

  mul_state_t    state_reg, state_next;
  logic [AW-1:0] acc_reg;
  logic [AW-1:0] mcand_reg;
  logic [W+2:0]  mplier_reg;
  logic [CW-1:0] count_reg;

  logic          accept;
  logic          last_step;
  logic          op1_sext;
  logic          op2_sext;
  logic [AW-1:0] pp;
  logic          pp_neg;
  logic [AW-1:0] acc_sum;
  logic          unused_acc_hi;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign accept    = in_ready && in_valid && !flush;
  assign last_step = (count_reg == CW'(ITER - 1));
  assign op1_sext  = op1_signed & op1[W-1];
  assign op2_sext  = op2_signed & op2[W-1];

  // The multiplicand is pre-shifted by 2 each step, so the window is always
  // the low three bits of the multiplier register and the adder stays fixed.
  booth_r4_sel #(
    .MW(AW)
  ) u_sel (
    .window(mplier_reg[2:0]),
    .mcand (mcand_reg),
    .pp    (pp),
    .neg   (pp_neg)
  );

  assign acc_sum       = acc_reg + pp + {{(AW-1){1'b0}}, pp_neg};
  assign res           = acc_reg[2*W-1:0];
  assign unused_acc_hi = ^acc_reg[AW-1:2*W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          state_next = IDLE;
        end else if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (flush || out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else if (accept) begin
      acc_reg    <= '0;
      mcand_reg  <= {{(AW-W){op1_sext}}, op1};
      mplier_reg <= {{2{op2_sext}}, op2, 1'b0};
      count_reg  <= '0;
    end else if (state_reg == BUSY) begin
      if (flush) begin
        acc_reg   <= '0;
        count_reg <= '0;
      end else begin
        acc_reg    <= acc_sum;
        mcand_reg  <= {mcand_reg[AW-3:0], 2'b00};
        mplier_reg <= {2'b00, mplier_reg[W+2:2]};
        count_reg  <= count_reg + CW'(1);
      end
    end else if (state_reg == DONE && flush) begin
      acc_reg <= '0;
    end
  end

endmodule

// File: tb/tb_mul_booth_iter.sv
// Randomised self-checking bench for mul_booth_iter at W=32 and W=8 against
// a plain-arithmetic product model.
module tb_mul_booth_iter;

  localparam int W     = 32;
  localparam int ITER  = W / 2 + 1;
  localparam int W8    = 8;
  localparam int ITER8 = W8 / 2 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, op1_signed, op2_signed, flush, out_valid, out_ready;
  logic [W-1:0]  op1, op2;
  logic [2*W-1:0] res;

  logic           in_valid8, in_ready8, op1_signed8, op2_signed8, flush8, out_valid8, out_ready8;
  logic [W8-1:0]  op1_8, op2_8;
  logic [2*W8-1:0] res8;

  int checks = 0;
  int errors = 0;

  mul_booth_iter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .op1_signed(op1_signed), .op2_signed(op2_signed),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .res(res)
  );

  mul_booth_iter #(.W(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .op1(op1_8), .op2(op2_8), .op1_signed(op1_signed8), .op2_signed(op2_signed8),
    .flush(flush8), .out_valid(out_valid8), .out_ready(out_ready8), .res(res8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb);
    logic [63:0] ea, eb;
    ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic sa, input logic sb);
    logic [15:0] ea, eb;
    ea = sa ? {{8{a[7]}}, a} : {8'b0, a};
    eb = sb ? {{8{b[7]}}, b} : {8'b0, b};
    return ea * eb;
  endfunction

  // Handshake one operand pair in; operand lines are scrambled right after.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_issue", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b1; op1 = a; op2 = b; op1_signed = sa; op2_signed = sb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op1 = $urandom; op2 = $urandom; op1_signed = 1'($urandom); op2_signed = 1'($urandom);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sa,
                       input logic sb, input int hold);
    int n;
    logic [63:0] exp;
    logic [63:0] held;
    exp = model32(a, b, sa, sb);
    issue(a, b, sa, sb);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, ITER);
    chk("res", res, exp);
    $display("op %h x %h s%0d%0d -> %h (exp %h) latency %0d", a, b, sa, sb, res, exp, n);
    held = res;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_res", res, held);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_ack_out_valid", out_valid, 0);
    chk("post_ack_in_ready", in_ready, 1);
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic sa, input logic sb);
    int n;
    logic [15:0] exp;
    exp = model8(a, b, sa, sb);
    @(negedge clk);
    chk("w8_in_ready", in_ready8, 1);
    in_valid8 = 1'b1; op1_8 = a; op2_8 = b; op1_signed8 = sa; op2_signed8 = sb;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0; op1_8 = 8'($urandom); op2_8 = 8'($urandom);
    n = 0;
    while (!out_valid8 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w8_latency", n, ITER8);
    chk("w8_res", res8, exp);
    $display("op8 %h x %h s%0d%0d -> %h (exp %h) latency %0d", a, b, sa, sb, res8, exp, n);
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
    chk("w8_post_ack_in_ready", in_ready8, 1);
  endtask

  task automatic count_spurious(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk(tag, seen, 0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    in_valid = 0; op1 = '0; op2 = '0; op1_signed = 0; op2_signed = 0; flush = 0; out_ready = 0;
    in_valid8 = 0; op1_8 = '0; op2_8 = '0; op1_signed8 = 0; op2_signed8 = 0; flush8 = 0;
    out_ready8 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_res", res, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(32'd15, 32'd14940, 1, 1, 0);
    do_op(32'd15, 32'hFFFF_C5A4, 1, 1, 0);
    chk("vec_neg_ss", res, 64'hFFFF_FFFF_FFFC_949C);
    do_op(32'd15, 32'hFFFF_C5A4, 1, 0, 0);
    chk("vec_neg_su", res, 64'h0000_000E_FFFC_949C);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    chk("vec_max_uu", res, 64'hFFFF_FFFE_0000_0001);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 0);
    chk("vec_m1_ss", res, 64'h0000_0000_0000_0001);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0);
    chk("vec_m1_su", res, 64'hFFFF_FFFF_0000_0001);
    do_op(32'h8000_0000, 32'h8000_0000, 1, 1, 0);
    chk("vec_min_ss", res, 64'h4000_0000_0000_0000);

    // Back-pressure: result held 10 cycles, then a fresh op must be accepted.
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 0, 1, 10);
    do_op(32'd7, 32'd9, 0, 0, 0);

    // Flush during BUSY.
    issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_out_valid", out_valid, 0);
    count_spurious("flush_no_out_valid", 25);

    // Flush in IDLE wins over in_valid.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op1 = 32'd2; op2 = 32'd3;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("idle_flush_no_accept", in_ready, 1);
    count_spurious("idle_flush_no_out_valid", 20);

    // Reset during BUSY.
    issue(32'h0001_0000, 32'h0002_0000, 0, 0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_spurious("rst_no_out_valid", 25);
    do_op(32'd3, 32'd5, 1, 1, 0);
    chk("rst_then_15", res, 64'd15);

    for (int i = 0; i < 30; i++) begin
      do_op(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), 0);
    end

    do_op8(8'h80, 8'h80, 1, 1);
    chk("w8_min_ss", res8, 16'h4000);
    do_op8(8'hFF, 8'hFF, 0, 0);
    for (int i = 0; i < 12; i++) begin
      do_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
